an_rx_tone_gate: RTL and testbench

Tone gate for the AN receiver, placed directly after the level detector. It takes the detector's 12-bit magnitude sample and its completion strobe, and decides tone ON/OFF using dual thresholds and a debounce count. Each confirmed ON/OFF segment is reported as a {tone, duration} event through a small valid/ready FIFO to the symbol decoder.

---
 rtl/an_rx_pkg.sv | 22 ++
 rtl/an_rx_ev_fifo.sv | 60 ++++++
 rtl/an_rx_tone_gate.sv | 148 ++++++++++++++
 tb/tb_an_rx_tone_gate.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/an_rx_pkg.sv
// Shared types and default parameters for the AN receiver tone gate.
package an_rx_pkg;

  localparam logic [11:0] C_ON_TH_DEF  = 12'h200;
  localparam logic [11:0] C_OFF_TH_DEF = 12'h100;
  localparam int          C_DEB_N_DEF  = 3;
  localparam int          C_DUR_W_DEF  = 16;
  localparam int          C_DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_ON_PEND  = 2'd1,
    ST_ON       = 2'd2,
    ST_OFF_PEND = 2'd3
  } state_t;

  typedef struct packed {
    logic                   tone;
    logic [C_DUR_W_DEF-1:0] dur;
  } ev_t;

endpackage

// File: rtl/an_rx_ev_fifo.sv
// Small synchronous event FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle, otherwise it is dropped and flagged.
module an_rx_ev_fifo #(
  parameter int C_WIDTH = 17,
  parameter int C_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_srst,
  input  logic               i_push,
  input  logic [C_WIDTH-1:0] i_data,
  output logic               o_full,
  output logic               o_drop,
  input  logic               i_pop,
  output logic               o_valid,
  output logic [C_WIDTH-1:0] o_data
);

  localparam int C_AW = $clog2(C_DEPTH);
  localparam logic [C_AW:0] C_CNT_FULL = (C_AW+1)'(C_DEPTH);
  localparam logic [C_AW:0] C_CNT_ONE  = (C_AW+1)'(1);
  localparam logic [C_AW-1:0] C_PTR_ONE = C_AW'(1);

  logic [C_WIDTH-1:0] r_mem [C_DEPTH];
  logic [C_AW-1:0]    r_wr;
  logic [C_AW-1:0]    r_rd;
  logic [C_AW:0]      r_cnt;
  logic               w_pop;
  logic               w_wr;

  assign o_valid = (r_cnt != '0);
  assign o_full  = (r_cnt == C_CNT_FULL);
  assign w_pop   = i_pop && o_valid;
  assign w_wr    = i_push && (!o_full || w_pop);
  assign o_drop  = i_push && o_full && !w_pop;
  assign o_data  = o_valid ? r_mem[r_rd] : '0;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr)
        r_wr <= r_wr + C_PTR_ONE;
      if (w_pop)
        r_rd <= r_rd + C_PTR_ONE;
      if (w_wr && !w_pop)
        r_cnt <= r_cnt + C_CNT_ONE;
      else if (w_pop && !w_wr)
        r_cnt <= r_cnt - C_CNT_ONE;
    end
  end

  // Storage needs no reset: the read side is gated by the occupancy count.
  always_ff @(posedge i_clk) begin
    if (!i_srst && w_wr)
      r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/an_rx_tone_gate.sv
// Hysteresis + debounce tone gate reporting {tone, duration} segment events.
// Optional smoothing of the input level when AN_RX_TONE_GATE_IIR_EN is defined.
module an_rx_tone_gate
  import an_rx_pkg::*;
#(
  parameter logic [11:0] C_ON_TH  = C_ON_TH_DEF,
  parameter logic [11:0] C_OFF_TH = C_OFF_TH_DEF,
  parameter int          C_DEB_N  = C_DEB_N_DEF,
  parameter int          C_DUR_W  = C_DUR_W_DEF,
  parameter int          C_DEPTH  = C_DEPTH_DEF
) (
  input  logic               CK_i,
  input  logic               SRST_i,
  input  logic [11:0]        LVs_i,
  input  logic               DONE_i,
  output logic               TONE_o,
  output logic               EV_VALID_o,
  input  logic               EV_READY_i,
  output logic               EV_TONE_o,
  output logic [C_DUR_W-1:0] EV_DURs_o,
  output logic               OVF_o
);

  localparam logic [C_DUR_W-1:0] C_DUR_MAX = '1;
  localparam logic [C_DUR_W-1:0] C_DUR_ONE = C_DUR_W'(1);
  localparam logic [C_DUR_W-1:0] C_DEB_D   = C_DUR_W'(C_DEB_N);
  localparam logic [3:0]         C_DEB_P   = 4'(C_DEB_N);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_pend;
  logic [3:0]         w_pend_nxt;
  logic [3:0]         w_pend_inc;
  logic [C_DUR_W-1:0] r_dur;
  logic [C_DUR_W-1:0] w_dur_nxt;
  logic [C_DUR_W-1:0] w_dur_inc;
  logic [C_DUR_W-1:0] w_ev_dur;
  logic               r_ovf;
  logic [11:0]        w_lv;
  logic               w_hi;
  logic               w_lo;
  logic               w_tone;
  logic               w_opp;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_unused_full;
  logic [C_DUR_W:0]   w_head;

`ifdef AN_RX_TONE_GATE_IIR_EN
  logic signed [13:0] r_filt;
  logic signed [13:0] w_diff;
  logic signed [13:0] w_filt_nxt;

  assign w_diff     = $signed({2'b00, LVs_i}) - r_filt;
  assign w_filt_nxt = r_filt + (w_diff >>> 2);
  assign w_lv       = w_filt_nxt[11:0];

  always_ff @(posedge CK_i) begin
    if (SRST_i)
      r_filt <= '0;
    else if (DONE_i)
      r_filt <= w_filt_nxt;
  end
`else
  assign w_lv = LVs_i;
`endif

  assign w_hi       = (w_lv >= C_ON_TH);
  assign w_lo       = (w_lv < C_OFF_TH);
  assign w_tone     = (r_state == ST_ON) || (r_state == ST_OFF_PEND);
  assign w_opp      = w_tone ? w_lo : w_hi;
  assign w_pend_inc = r_pend + 4'd1;
  assign w_dur_inc  = (r_dur == C_DUR_MAX) ? r_dur : r_dur + C_DUR_ONE;
  // The confirming run of opposite samples belongs to the new segment.
  assign w_ev_dur   = (r_dur == C_DUR_MAX) ? C_DUR_MAX : r_dur + C_DUR_ONE - C_DEB_D;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_dur_nxt   = r_dur;
    w_push      = 1'b0;
    if (DONE_i) begin
      w_dur_nxt = w_dur_inc;
      if (w_opp) begin
        if (w_pend_inc == C_DEB_P) begin
          w_push     = 1'b1;
          w_pend_nxt = '0;
          w_dur_nxt  = C_DEB_D;
          if (w_tone)
            w_state_nxt = ST_OFF;
          else
            w_state_nxt = ST_ON;
        end else begin
          w_pend_nxt = w_pend_inc;
          if (w_tone)
            w_state_nxt = ST_OFF_PEND;
          else
            w_state_nxt = ST_ON_PEND;
        end
      end else begin
        w_pend_nxt = '0;
        if (w_tone)
          w_state_nxt = ST_ON;
        else
          w_state_nxt = ST_OFF;
      end
    end
  end

  always_ff @(posedge CK_i) begin
    if (SRST_i) begin
      r_state <= ST_OFF;
      r_pend  <= '0;
      r_dur   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_dur   <= w_dur_nxt;
      if (w_drop)
        r_ovf <= 1'b1;
    end
  end

  assign w_pop = EV_VALID_o && EV_READY_i;

  an_rx_ev_fifo #(
    .C_WIDTH (C_DUR_W + 1),
    .C_DEPTH (C_DEPTH)
  ) u_ev_fifo (
    .i_clk   (CK_i),
    .i_srst  (SRST_i),
    .i_push  (w_push),
    .i_data  ({w_tone, w_ev_dur}),
    .o_full  (w_unused_full),
    .o_drop  (w_drop),
    .i_pop   (w_pop),
    .o_valid (EV_VALID_o),
    .o_data  (w_head)
  );

  assign TONE_o    = w_tone;
  assign OVF_o     = r_ovf;
  assign EV_TONE_o = w_head[C_DUR_W];
  assign EV_DURs_o = w_head[C_DUR_W-1:0];

endmodule

// File: tb/tb_an_rx_tone_gate.sv
// Scoreboard bench for the tone gate: default instance plus a 4-bit duration instance.
module tb_an_rx_tone_gate;

   localparam logic [11:0] LV_LO  = 12'h050;
   localparam logic [11:0] LV_HI  = 12'h300;
   localparam logic [11:0] LV_MID = 12'h180;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] lvIn;
   logic        doneIn;
   logic        toneOut;
   logic        evValid;
   logic        evReady;
   logic        evTone;
   logic [15:0] evDur;
   logic        ovfOut;

   logic [11:0] lvS;
   logic        doneS;
   logic        toneS;
   logic        evValidS;
   logic        evToneS;
   logic [3:0]  evDurS;
   logic        ovfS;

   int checks = 0;
   int errors = 0;

   logic [16:0] expQ [$];
   logic [4:0]  expQS [$];

   // Free-running clock shared by both instances.
   always #5 clock = ~clock;

   an_rx_tone_gate dut (
      .CK_i       (clock),
      .SRST_i     (reset),
      .LVs_i      (lvIn),
      .DONE_i     (doneIn),
      .TONE_o     (toneOut),
      .EV_VALID_o (evValid),
      .EV_READY_i (evReady),
      .EV_TONE_o  (evTone),
      .EV_DURs_o  (evDur),
      .OVF_o      (ovfOut)
   );

   an_rx_tone_gate #(.C_DUR_W(4)) dutSat (
      .CK_i       (clock),
      .SRST_i     (reset),
      .LVs_i      (lvS),
      .DONE_i     (doneS),
      .TONE_o     (toneS),
      .EV_VALID_o (evValidS),
      .EV_READY_i (1'b1),
      .EV_TONE_o  (evToneS),
      .EV_DURs_o  (evDurS),
      .OVF_o      (ovfS)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // One sample to the default instance; returns 1 time unit after the edge.
   task automatic applyStimulus(input logic [11:0] lv);
      lvIn   = lv;
      doneIn = 1'b1;
      @(posedge clock);
      #1;
      doneIn = 1'b0;
   endtask

   task automatic applyStimulusSat(input logic [11:0] lv);
      lvS   = lv;
      doneS = 1'b1;
      @(posedge clock);
      #1;
      doneS = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      expQ.delete();
      expQS.delete();
   endtask

   task automatic pushExp(input logic tone, input logic [15:0] dur);
      expQ.push_back({tone, dur});
   endtask

   // Stable run of 'stable' samples at the current level, then a confirming run.
   task automatic segment(input logic curTone, input int stable);
      for (int i = 0; i < stable; i++)
         applyStimulus(curTone ? LV_HI : LV_LO);
      for (int i = 0; i < 3; i++)
         applyStimulus(curTone ? LV_LO : LV_HI);
   endtask

   // Monitors: every accepted head is compared against the scoreboard.
   always @(negedge clock) begin
      if (!reset && evValid && evReady) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event: got {%0d,%0h}, required none", evTone, evDur);
         end else begin
            checkOutput("event", 32'({evTone, evDur}), 32'(expQ.pop_front()));
         end
      end
   end

   always @(negedge clock) begin
      if (!reset && evValidS) begin
         if (expQS.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event_sat: got {%0d,%0h}, required none", evToneS, evDurS);
         end else begin
            checkOutput("event_sat", 32'({evToneS, evDurS}), 32'(expQS.pop_front()));
         end
      end
   end

   initial begin
      reset   = 1'b1;
      lvIn    = '0;
      doneIn  = 1'b0;
      evReady = 1'b1;
      lvS     = '0;
      doneS   = 1'b0;
      @(posedge clock);
      #1;
      doReset();

      checkOutput("rst_tone", 32'(toneOut), 0);
      checkOutput("rst_valid", 32'(evValid), 0);
      checkOutput("rst_ev_tone", 32'(evTone), 0);
      checkOutput("rst_ev_dur", 32'(evDur), 0);
      checkOutput("rst_ovf", 32'(ovfOut), 0);
      checkOutput("rst_sat_valid", 32'(evValidS), 0);

      // Basic OFF->ON->OFF with 10/8/5 samples.
      for (int i = 1; i <= 10; i++) applyStimulus(LV_LO);
      for (int i = 1; i <= 8; i++) begin
         if (i == 3) pushExp(1'b0, 16'd10);
         applyStimulus(LV_HI);
         if (i == 2) begin
            checkOutput("tone_before_rise", 32'(toneOut), 0);
            checkOutput("valid_before_rise", 32'(evValid), 0);
         end
         if (i == 3) begin
            checkOutput("tone_rise", 32'(toneOut), 1);
            checkOutput("valid_latency", 32'(evValid), 1);
         end
      end
      for (int i = 1; i <= 5; i++) begin
         if (i == 3) pushExp(1'b1, 16'd8);
         applyStimulus(LV_LO);
         if (i == 2) checkOutput("tone_before_fall", 32'(toneOut), 1);
         if (i == 3) checkOutput("tone_fall", 32'(toneOut), 0);
      end
      idle(3);

      // Aborted pend: the two HI and all LO samples stay in one OFF segment.
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(LV_LO);
      applyStimulus(LV_HI);
      applyStimulus(LV_HI);
      applyStimulus(LV_LO);
      checkOutput("glitch_tone", 32'(toneOut), 0);
      checkOutput("glitch_no_event", 32'(evValid), 0);
      for (int i = 0; i < 3; i++) applyStimulus(LV_LO);
      pushExp(1'b0, 16'd11);
      for (int i = 0; i < 3; i++) applyStimulus(LV_HI);
      checkOutput("glitch_tone_on", 32'(toneOut), 1);

      // Hysteresis while ON: MID samples never count as off.
      applyStimulus(LV_LO);
      applyStimulus(LV_LO);
      applyStimulus(LV_MID);
      applyStimulus(LV_LO);
      applyStimulus(LV_LO);
      for (int i = 0; i < 20; i++) applyStimulus(LV_MID);
      checkOutput("hyst_tone", 32'(toneOut), 1);
      checkOutput("hyst_no_event", 32'(evValid), 0);

      // Overflow: five events with the consumer stalled; only four fit.
      doReset();
      evReady = 1'b0;
      pushExp(1'b0, 16'd1);
      segment(1'b0, 1);
      pushExp(1'b1, 16'd5);
      segment(1'b1, 2);
      pushExp(1'b0, 16'd6);
      segment(1'b0, 3);
      pushExp(1'b1, 16'd7);
      segment(1'b1, 4);
      checkOutput("full_no_ovf", 32'(ovfOut), 0);
      segment(1'b0, 5);
      checkOutput("ovf_set", 32'(ovfOut), 1);
      checkOutput("ovf_valid", 32'(evValid), 1);
      idle(2);
      checkOutput("hold_head", 32'({evTone, evDur}), 32'({1'b0, 16'd1}));
      evReady = 1'b1;
      idle(8);
      checkOutput("drained", 32'(evValid), 0);
      checkOutput("ovf_sticky", 32'(ovfOut), 1);

      // Reset with three events queued and the FSM in ON_PEND.
      doReset();
      evReady = 1'b0;
      pushExp(1'b0, 16'd1);
      segment(1'b0, 1);
      segment(1'b1, 2);
      segment(1'b0, 3);
      segment(1'b1, 4);
      evReady = 1'b1;
      idle(1);
      evReady = 1'b0;
      applyStimulus(LV_HI);
      applyStimulus(LV_HI);
      doReset();
      checkOutput("srst_valid", 32'(evValid), 0);
      checkOutput("srst_tone", 32'(toneOut), 0);
      checkOutput("srst_ovf", 32'(ovfOut), 0);
      evReady = 1'b1;
      pushExp(1'b0, 16'd6);
      segment(1'b0, 6);
      idle(3);

      // Saturating 4-bit duration.
      for (int i = 0; i < 20; i++) applyStimulusSat(LV_LO);
      expQS.push_back({1'b0, 4'hF});
      for (int i = 0; i < 3; i++) applyStimulusSat(LV_HI);
      checkOutput("sat_tone", 32'(toneS), 1);
      idle(3);
      checkOutput("sat_ovf", 32'(ovfS), 0);

      checkOutput("scoreboard_empty", 32'(expQ.size()), 0);
      checkOutput("scoreboard_sat_empty", 32'(expQS.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
